// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry, fill FSM state type and the
// block-alignment helper used when latching a miss address.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_IDX_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned OFFSET_W    = WORD_IDX_W + 1;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    // Clears the low offset_w bits of a byte address (up to 32 bits wide).
    function automatic logic [31:0] block_base(input logic [31:0] addr,
                                               input int unsigned offset_w);
        return addr & ~((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Small up-counter used for the fill request and response indices: synchronous
// clear, increment enable and a flag raised while the count equals TERMINAL.
module fill_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count       = count_q;
    assign at_terminal = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches the aligned block holding a missing address,
// one word request per cycle, streaming responses into the data array and tagging on the last.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    output logic                           fsm_busy,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    input  logic                           mem_data_valid,
    input  logic [15:0]                    mem_data,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array,
    output logic [ADDR_WIDTH-1:0]          fill_base
);

    localparam int unsigned IdxW  = $clog2(BLOCK_WORDS);
    localparam int unsigned CntW  = IdxW + 1;
    localparam int unsigned OffW  = IdxW + 1;

    fill_state_t     state;
    logic            in_fill;
    logic            start;
    logic            cnt_clr;
    logic [CntW-1:0] req_cnt;
    logic [CntW-1:0] rsp_cnt;
    logic            req_done;
    logic            rsp_last;

    assign in_fill = (state == FILL);
    assign start   = (state == IDLE) && miss_detected;
    // Clearing on completion keeps both counters at zero for the whole idle period.
    assign cnt_clr = start || write_tag_array;

    fill_counter #(
        .WIDTH    (CntW),
        .TERMINAL (BLOCK_WORDS)
    ) u_req_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr),
        .en          (mem_enable),
        .count       (req_cnt),
        .at_terminal (req_done)
    );

    fill_counter #(
        .WIDTH    (CntW),
        .TERMINAL (BLOCK_WORDS - 1)
    ) u_rsp_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr),
        .en          (write_data_array),
        .count       (rsp_cnt),
        .at_terminal (rsp_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fsm_busy  <= 1'b0;
            fill_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state     <= FILL;
                        fsm_busy  <= 1'b1;
                        fill_base <= ADDR_WIDTH'(block_base(32'(miss_address), OffW));
                    end
                end
                FILL: begin
                    if (write_tag_array) begin
                        state    <= IDLE;
                        fsm_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_wr           = 1'b0;
        mem_enable       = in_fill && !req_done;
        mem_address      = '0;
        if (mem_enable) begin
            mem_address = fill_base + ADDR_WIDTH'({req_cnt, 1'b0});
        end

        // The MSB guard only matters if memory returned more words than requested.
        write_data_array = in_fill && mem_data_valid && !rsp_cnt[IdxW];
        write_tag_array  = write_data_array && rsp_last;
        fill_word_idx    = '0;
        fill_data        = '0;
        if (write_data_array) begin
            fill_word_idx = rsp_cnt[IdxW-1:0];
            fill_data     = mem_data;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a fixed-latency memory model feeds the DUT,
// stimulus pushes expected requests/writes/tags and a negedge monitor checks them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        fsm_busy;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_address;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        write_data_array;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] fill_base;

    cache_fill_fsm #(
        .ADDR_WIDTH  (16),
        .BLOCK_WORDS (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .mem_wr           (mem_wr),
        .mem_address      (mem_address),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .write_data_array (write_data_array),
        .fill_word_idx    (fill_word_idx),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array),
        .fill_base        (fill_base)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
    endfunction

    // Memory model: fixed latency lat, one request per cycle, plus an injector.
    int          lat = 0;
    logic        inj = 1'b0;
    logic [7:0]  pv = 8'h00;
    logic [15:0] pa [8];
    logic        rv;
    logic [15:0] ra;

    always @(posedge clk) begin
        pv    <= {pv[6:0], mem_enable};
        pa[0] <= mem_address;
        for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end

    always_comb begin
        rv = 1'b0;
        ra = 16'h0;
        if (lat == 0) begin
            rv = mem_enable;
            ra = mem_address;
        end else begin
            rv = pv[lat-1];
            ra = pa[lat-1];
        end
        mem_data_valid = rv | inj;
        mem_data       = inj ? 16'hBEEF : (rv ? memf(ra) : 16'h0);
    end

    // Scoreboard queues
    logic [15:0] req_a_q[$];
    int          req_c_q[$];
    int          wr_i_q[$];
    logic [15:0] wr_d_q[$];
    int          wr_c_q[$];
    logic [15:0] tag_b_q[$];
    int          tag_c_q[$];
    int          rise_q[$];
    int          fall_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event value %0h, expected none (cycle %0d)",
                 name, act, cyc);
    endtask

    task automatic push_fill(input logic [15:0] base, input int c0, input int l,
                             input int nreq, input int nwr, input bit tag, input int fall);
        for (int i = 0; i < nreq; i++) begin
            req_a_q.push_back(base + 16'(2 * i));
            req_c_q.push_back(c0 + i);
        end
        for (int i = 0; i < nwr; i++) begin
            wr_i_q.push_back(i);
            wr_d_q.push_back(memf(base + 16'(2 * i)));
            wr_c_q.push_back(c0 + l + i);
        end
        if (tag) begin
            tag_b_q.push_back(base);
            tag_c_q.push_back(c0 + 7 + l);
        end
        rise_q.push_back(c0);
        fall_q.push_back(fall);
    endtask

    // Monitor
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        chk("mem_wr", 32'(mem_wr), 32'h0);
        if (mem_enable) begin
            if (req_a_q.size() == 0) unexpected("req", 32'(mem_address));
            else begin
                chk("req_addr", 32'(mem_address), 32'(req_a_q.pop_front()));
                chk("req_cycle", cyc, req_c_q.pop_front());
            end
        end else begin
            chk("addr_idle_zero", 32'(mem_address), 32'h0);
        end
        if (write_data_array) begin
            if (wr_i_q.size() == 0) unexpected("write", 32'(fill_data));
            else begin
                chk("wr_idx", 32'(fill_word_idx), wr_i_q.pop_front());
                chk("wr_data", 32'(fill_data), 32'(wr_d_q.pop_front()));
                chk("wr_cycle", cyc, wr_c_q.pop_front());
            end
        end else begin
            chk("idx_idle_zero", 32'(fill_word_idx), 32'h0);
            chk("data_idle_zero", 32'(fill_data), 32'h0);
        end
        if (write_tag_array) begin
            if (tag_b_q.size() == 0) unexpected("tag", 32'(fill_base));
            else begin
                chk("tag_base", 32'(fill_base), 32'(tag_b_q.pop_front()));
                chk("tag_cycle", cyc, tag_c_q.pop_front());
            end
        end
        if (fsm_busy && !prev_busy) begin
            if (rise_q.size() == 0) unexpected("busy_rise", cyc);
            else chk("busy_rise_cycle", cyc, rise_q.pop_front());
        end
        if (!fsm_busy && prev_busy) begin
            if (fall_q.size() == 0) unexpected("busy_fall", cyc);
            else chk("busy_fall_cycle", cyc, fall_q.pop_front());
        end
        prev_busy = fsm_busy;
    end

    // Returns c0 = value of cyc during cycle 1 of the fill.
    task automatic start_miss(input logic [15:0] a, output int c0);
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = a;
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (fsm_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (fsm_busy) unexpected({name, "_timeout"}, 32'(n));
        repeat (10) @(negedge clk);
    endtask

    task automatic do_fill(input logic [15:0] a, input int l);
        int c0;
        lat = l;
        start_miss(a, c0);
        miss_detected = 1'b0;
        push_fill(a & 16'hFFF0, c0, l, 8, 8, 1'b1, c0 + 8 + l);
        wait_idle("fill");
    endtask

    int lat_tab [3] = '{0, 1, 7};

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(fsm_busy), 32'h0);
        chk("rst_mem_enable", 32'(mem_enable), 32'h0);
        chk("rst_write_data", 32'(write_data_array), 32'h0);
        chk("rst_write_tag", 32'(write_tag_array), 32'h0);
        chk("rst_fill_base", 32'(fill_base), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_fill(16'h1234, 0);
        do_fill(16'hFFFF, 4);

        // Miss re-asserted during a fill, held through the cycle busy falls.
        lat = 1;
        start_miss(16'h0100, c0);
        miss_detected = 1'b0;
        push_fill(16'h0100, c0, 1, 8, 8, 1'b1, c0 + 9);
        push_fill(16'h0040, c0 + 10, 1, 8, 8, 1'b1, c0 + 19);
        repeat (2) @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h0040;
        repeat (9) @(negedge clk);
        miss_detected = 1'b0;
        wait_idle("b2b");

        // Spurious response while idle.
        @(posedge clk);
        #1 inj = 1'b1;
        @(negedge clk);
        chk("spurious_no_write", 32'(write_data_array), 32'h0);
        chk("spurious_idx", 32'(fill_word_idx), 32'h0);
        @(posedge clk);
        #1 inj = 1'b0;
        do_fill(16'h0A06, 2);

        // Reset in cycle 5 of an L=3 fill.
        lat = 3;
        start_miss(16'h0500, c0);
        miss_detected = 1'b0;
        push_fill(16'h0500, c0, 3, 5, 2, 1'b0, c0 + 5);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle("reset");
        do_fill(16'h0200, 3);

        for (int k = 0; k < 6; k++) begin
            do_fill(16'($urandom), lat_tab[k % 3]);
        end

        chk("req_q_empty", req_a_q.size(), 0);
        chk("wr_q_empty", wr_i_q.size(), 0);
        chk("tag_q_empty", tag_b_q.size(), 0);
        chk("rise_q_empty", rise_q.size(), 0);
        chk("fall_q_empty", fall_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
